output_grad_seq: RTL and testbench

OUTPUT_GRAD_SEQ -- requirements
Module: output_grad_seq

---
 rtl/nn_pkg.sv | 20 ++
 rtl/sat_sub.sv | 25 ++
 rtl/output_grad_seq.sv | 82 ++++++++
 tb/tb_output_grad_seq.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared Q8.8 constants and the train-step FSM state encoding for the
// output-gradient sequencer.
package nn_pkg;

    localparam int DEF_BITS = 16;

    localparam logic [15:0] Q_ONE = 16'h0100;
    localparam logic [15:0] Q_MAX = 16'h7FFF;
    localparam logic [15:0] Q_MIN = 16'h8000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FWD,
        S_CAP,
        S_GRAD,
        S_BWD,
        S_DONE
    } state_t;

endpackage

// File: rtl/sat_sub.sv
// Combinational saturating signed subtract y = a - b; the difference is formed
// one bit wider and clamped to the most positive/negative BITS-wide value.
module sat_sub #(
    parameter int BITS = 16
) (
    input  logic [BITS-1:0] a,
    input  logic [BITS-1:0] b,
    output logic [BITS-1:0] y
);

    localparam logic [BITS-1:0] SAT_MAX = {1'b0, {(BITS-1){1'b1}}};
    localparam logic [BITS-1:0] SAT_MIN = {1'b1, {(BITS-1){1'b0}}};

    logic [BITS:0] diff;

    always_comb begin
        diff = {a[BITS-1], a} - {b[BITS-1], b};
        y    = diff[BITS-1:0];
        // Top two bits disagree only when the result does not fit in BITS.
        if (diff[BITS] != diff[BITS-1]) begin
            y = diff[BITS] ? SAT_MIN : SAT_MAX;
        end
    end

endmodule

// File: rtl/output_grad_seq.sv
// Sequences one train step for an output-layer neuron: forward strobe, capture
// of the ReLU output, gradient dZ = relu'(y) * sat(y - target), backward strobe.
module output_grad_seq
    import nn_pkg::*;
#(
    parameter int BITS      = DEF_BITS,
    parameter int FP_CYCLES = 8,
    parameter int BP_CYCLES = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [BITS-1:0] target,
    input  logic [BITS-1:0] y_in,
    output logic            FP,
    output logic            BP,
    output logic [BITS-1:0] dZ_out,
    output logic [BITS-1:0] W_out,
    output logic            busy,
    output logic            done
);

    state_t          state, state_n;
    logic [7:0]      cnt;
    logic [BITS-1:0] target_q;
    logic [BITS-1:0] y_q;
    logic [BITS-1:0] diff;
    logic            relu_zero;

    sat_sub #(.BITS(BITS)) u_sat_sub (
        .a (y_q),
        .b (target_q),
        .y (diff)
    );

    assign relu_zero = y_q[BITS-1] | (y_q == '0);
    assign W_out     = BITS'(Q_ONE);

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: if (start) state_n = S_FWD;
            S_FWD:  if (cnt == 8'(FP_CYCLES - 1)) state_n = S_CAP;
            S_CAP:  state_n = S_GRAD;
            S_GRAD: state_n = S_BWD;
            S_BWD:  if (cnt == 8'(BP_CYCLES - 1)) state_n = S_DONE;
            S_DONE: state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Strobes are registered from the next state so they line up with the
    // state they belong to without a cycle of lag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            target_q <= '0;
            y_q      <= '0;
            dZ_out   <= '0;
            FP       <= 1'b0;
            BP       <= 1'b0;
            done     <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state <= state_n;
            if (state_n != state) begin
                cnt <= '0;
            end else if (state == S_FWD || state == S_BWD) begin
                cnt <= cnt + 8'd1;
            end
            if (state == S_IDLE && start) target_q <= target;
            if (state == S_CAP)           y_q      <= y_in;
            if (state == S_GRAD)          dZ_out   <= relu_zero ? '0 : diff;
            FP   <= (state_n == S_FWD);
            BP   <= (state_n == S_BWD);
            done <= (state_n == S_DONE);
            busy <= (state_n != S_IDLE);
        end
    end

endmodule

// File: tb/tb_output_grad_seq.sv
// Directed bench for output_grad_seq: table of train steps checked cycle by
// cycle, plus reset-abort sequences and a single-cycle-strobe build.
module tb_output_grad_seq;

    localparam int FPC = 8;
    localparam int BPC = 8;

    typedef struct {
        logic [15:0] y;
        logic [15:0] tgt;
        logic [15:0] dz;
        bit          noise;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        start1;
    logic [15:0] target;
    logic [15:0] y_in;
    logic        FP, BP, busy, done;
    logic [15:0] dZ_out, W_out;
    logic        FP1, BP1, busy1, done1;
    logic [15:0] dZ_out1, W_out1;

    int          tests = 0;
    int          fails = 0;
    logic [15:0] dz_model = '0;
    vec_t        vecs[9];

    always #5 clk = ~clk;

    output_grad_seq #(.BITS(16), .FP_CYCLES(FPC), .BP_CYCLES(BPC)) u_dut (
        .clk(clk), .rst(rst), .start(start), .target(target), .y_in(y_in),
        .FP(FP), .BP(BP), .dZ_out(dZ_out), .W_out(W_out), .busy(busy), .done(done)
    );

    output_grad_seq #(.BITS(16), .FP_CYCLES(1), .BP_CYCLES(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .target(target), .y_in(y_in),
        .FP(FP1), .BP(BP1), .dZ_out(dZ_out1), .W_out(W_out1), .busy(busy1), .done(done1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Cycle n is the n-th clock period after the edge that samples start.
    task automatic run_step(input vec_t v, input int idx);
        int   fp_rises = 0;
        int   bp_rises = 0;
        logic fp_p = 1'b0;
        logic bp_p = 1'b0;
        logic [3:0] exp_ctl;
        @(negedge clk);
        y_in   = v.y;
        target = v.tgt;
        start  = 1'b1;
        for (int n = 1; n <= FPC + BPC + 6; n++) begin
            @(negedge clk);
            start = v.noise && (n == 3 || n == FPC + BPC + 3);
            if (n == 1) target = 16'hDEAD;
            if (n == FPC + 2) y_in = ~v.y;
            exp_ctl = {(n <= FPC),
                       (n >= FPC + 3 && n <= FPC + BPC + 2),
                       (n == FPC + BPC + 3),
                       (n <= FPC + BPC + 3)};
            check($sformatf("v%0d ctl n=%0d {FP,BP,done,busy}", idx, n),
                  {28'd0, FP, BP, done, busy}, {28'd0, exp_ctl});
            check($sformatf("v%0d dZ_out n=%0d", idx, n),
                  {16'd0, dZ_out}, {16'd0, (n <= FPC + 2) ? dz_model : v.dz});
            if (FP && !fp_p) fp_rises++;
            if (BP && !bp_p) bp_rises++;
            fp_p = FP;
            bp_p = BP;
        end
        check($sformatf("v%0d FP rises", idx), fp_rises, 1);
        check($sformatf("v%0d BP rises", idx), bp_rises, 1);
        dz_model = v.dz;
    endtask

    task automatic start_only(input logic [15:0] y, input logic [15:0] tgt);
        @(negedge clk);
        y_in   = y;
        target = tgt;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
    endtask

    initial begin
        vecs[0] = '{16'h0300, 16'h0100, 16'h0200, 1'b0};
        vecs[1] = '{16'h0000, 16'h0100, 16'h0000, 1'b0};
        vecs[2] = '{16'h7F00, 16'h8000, 16'h7FFF, 1'b0};
        vecs[3] = '{16'h0300, 16'h0100, 16'h0200, 1'b1};
        vecs[4] = '{16'h8100, 16'h0100, 16'h0000, 1'b0};
        vecs[5] = '{16'h0100, 16'h7F00, 16'h8200, 1'b0};
        vecs[6] = '{16'h0001, 16'h8000, 16'h7FFF, 1'b1};
        vecs[7] = '{16'h0080, 16'h0080, 16'h0000, 1'b0};
        vecs[8] = '{16'h0500, 16'hFF00, 16'h0600, 1'b0};

        rst    = 1'b1;
        start  = 1'b0;
        start1 = 1'b0;
        target = '0;
        y_in   = '0;
        repeat (2) @(negedge clk);
        check("reset {FP,BP,done,busy}", {28'd0, FP, BP, done, busy}, 32'd0);
        check("reset dZ_out", {16'd0, dZ_out}, 32'd0);
        check("reset W_out", {16'd0, W_out}, 32'h0100);
        rst = 1'b0;
        @(negedge clk);
        check("idle W_out", {16'd0, W_out}, 32'h0100);

        for (int i = 0; i < 9; i++) run_step(vecs[i], i);

        // Abort in the middle of the forward pass.
        start_only(16'h0300, 16'h0100);
        repeat (3) @(negedge clk);
        check("midFWD FP before rst", {31'd0, FP}, 32'd1);
        rst = 1'b1;
        #1;
        check("midFWD FP after rst", {31'd0, FP}, 32'd0);
        check("midFWD busy after rst", {31'd0, busy}, 32'd0);
        check("midFWD dZ_out after rst", {16'd0, dZ_out}, 32'd0);
        dz_model = '0;
        @(negedge clk);
        rst = 1'b0;

        // Abort on the third backward-pass cycle (cycle n = FPC + 5).
        start_only(16'h0300, 16'h0100);
        repeat (FPC + 4) @(negedge clk);
        check("midBWD BP before rst", {31'd0, BP}, 32'd1);
        check("midBWD dZ before rst", {16'd0, dZ_out}, 32'h0200);
        rst = 1'b1;
        #1;
        check("midBWD BP after rst", {31'd0, BP}, 32'd0);
        check("midBWD dZ_out after rst", {16'd0, dZ_out}, 32'd0);
        check("midBWD busy after rst", {31'd0, busy}, 32'd0);
        check("midBWD done after rst", {31'd0, done}, 32'd0);
        check("midBWD W_out during rst", {16'd0, W_out}, 32'h0100);
        dz_model = '0;
        @(negedge clk);
        rst = 1'b0;
        run_step('{16'h0200, 16'h0080, 16'h0180, 1'b0}, 100);

        // Single-cycle strobe build.
        @(negedge clk);
        y_in   = 16'h0300;
        target = 16'h0100;
        start1 = 1'b1;
        for (int n = 1; n <= 7; n++) begin
            @(negedge clk);
            start1 = 1'b0;
            check($sformatf("fp1 ctl n=%0d {FP,BP,done,busy}", n),
                  {28'd0, FP1, BP1, done1, busy1},
                  {28'd0, (n == 1), (n == 4), (n == 5), (n <= 5)});
            check($sformatf("fp1 dZ_out n=%0d", n),
                  {16'd0, dZ_out1}, {16'd0, (n <= 3) ? 16'h0000 : 16'h0200});
        end
        check("fp1 W_out", {16'd0, W_out1}, 32'h0100);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
